// File: rtl/rename_ctrl.sv
// Rename-stage sequencing controller: gates group acceptance and sequences RAT/freelist recovery.
// Optional performance counters are enabled with RENAME_CTRL_PERF_CNT_EN.
module rename_ctrl #(
   parameter int unsigned PREG_INDEX_WIDTH = 7,
   parameter int unsigned RECOVER_CYCLES   = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        decoder_valid,
   input  logic [3:0]                  instr_valid_vec,
   input  logic [3:0]                  rd_exist_vec,
   input  logic [PREG_INDEX_WIDTH:0]   freelist_count,
   input  logic                        dispatch_ready,
   input  logic                        rename_flush,
   input  logic                        recover_valid,
   output logic                        rename_ready,
   output logic                        alloc_req,
   output logic [2:0]                  alloc_num,
   output logic                        rat_update_en,
   output logic                        pipe_load,
   output logic                        rename_valid,
   output logic                        rat_recover_en,
   output logic                        freelist_recover_en,
   output logic                        recovering
`ifdef RENAME_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]                 stall_freelist_cnt,
   output logic [31:0]                 stall_dispatch_cnt,
   output logic [31:0]                 recover_cnt
`endif
);

   localparam int unsigned CNT_W = PREG_INDEX_WIDTH + 1;
   localparam int unsigned CTR_W = 4;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      RECOVER = 2'd1,
      SETTLE  = 2'd2
   } state_t;

   state_t             state, state_d;
   logic [CTR_W-1:0]   counter, counter_d;
   logic               rename_valid_d;
   logic [2:0]         need;
   logic               can_load;
   logic               fl_ok;
   logic               fire;

   // Preg demand of the incoming group and output-register availability.
   always_comb begin
      need = 3'd0;
      for (int i = 0; i < 4; i++) begin
         need = need + 3'(rd_exist_vec[i] & instr_valid_vec[i]);
      end
      can_load = !rename_valid || dispatch_ready;
      fl_ok    = freelist_count >= CNT_W'(need);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RUN;
         counter      <= '0;
         rename_valid <= 1'b0;
      end else begin
         state        <= state_d;
         counter      <= counter_d;
         rename_valid <= rename_valid_d;
      end
   end

   // Next-state logic; recovery outranks flush and fire.
   always_comb begin
      state_d        = state;
      counter_d      = counter;
      rename_valid_d = rename_valid;
      if (fire) begin
         rename_valid_d = 1'b1;
      end else if (dispatch_ready) begin
         rename_valid_d = 1'b0;
      end
      if (rename_flush || recover_valid) begin
         rename_valid_d = 1'b0;
      end
      if (recover_valid) begin
         state_d   = RECOVER;
         counter_d = '0;
      end else begin
         case (state)
            RECOVER: begin
               state_d   = SETTLE;
               counter_d = CTR_W'(RECOVER_CYCLES);
            end
            SETTLE: begin
               if (counter <= CTR_W'(1)) begin
                  state_d   = RUN;
                  counter_d = '0;
               end else begin
                  counter_d = counter - CTR_W'(1);
               end
            end
            default: begin
               state_d   = RUN;
               counter_d = '0;
            end
         endcase
      end
   end

   // Output logic; everything reads 0 while reset is asserted.
   always_comb begin
      rename_ready        = 1'b0;
      fire                = 1'b0;
      alloc_req           = 1'b0;
      alloc_num           = 3'd0;
      rat_update_en       = 1'b0;
      pipe_load           = 1'b0;
      rat_recover_en      = 1'b0;
      freelist_recover_en = 1'b0;
      recovering          = 1'b0;
      if (rst_n) begin
         recovering = (state != RUN);
         if (state == RUN) begin
            rename_ready = !recover_valid && !rename_flush && can_load && fl_ok;
         end
         if (state == RECOVER) begin
            rat_recover_en      = 1'b1;
            freelist_recover_en = 1'b1;
         end
         fire = decoder_valid && rename_ready;
         if (fire) begin
            pipe_load     = 1'b1;
            rat_update_en = 1'b1;
            alloc_req     = (need != 3'd0);
            alloc_num     = (need != 3'd0) ? need : 3'd0;
         end
      end
   end

`ifdef RENAME_CTRL_PERF_CNT_EN
   // Stall and recovery event counters, free-running and wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_freelist_cnt <= '0;
         stall_dispatch_cnt <= '0;
         recover_cnt        <= '0;
      end else begin
         if (state == RUN && decoder_valid && can_load && !fl_ok && !rename_flush && !recover_valid) begin
            stall_freelist_cnt <= stall_freelist_cnt + 32'd1;
         end
         if (state == RUN && decoder_valid && !can_load) begin
            stall_dispatch_cnt <= stall_dispatch_cnt + 32'd1;
         end
         if (state == RECOVER) begin
            recover_cnt <= recover_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_rename_ctrl.sv
// Directed bench for rename_ctrl: vector table for single-cycle acceptance, sequences for recovery.
module tb_rename_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       decoder_valid;
   logic [3:0] instr_valid_vec;
   logic [3:0] rd_exist_vec;
   logic [7:0] freelist_count;
   logic       dispatch_ready;
   logic       rename_flush;
   logic       recover_valid;
   logic       rename_ready;
   logic       alloc_req;
   logic [2:0] alloc_num;
   logic       rat_update_en;
   logic       pipe_load;
   logic       rename_valid;
   logic       rat_recover_en;
   logic       freelist_recover_en;
   logic       recovering;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rename_ctrl dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .decoder_valid       (decoder_valid),
      .instr_valid_vec     (instr_valid_vec),
      .rd_exist_vec        (rd_exist_vec),
      .freelist_count      (freelist_count),
      .dispatch_ready      (dispatch_ready),
      .rename_flush        (rename_flush),
      .recover_valid       (recover_valid),
      .rename_ready        (rename_ready),
      .alloc_req           (alloc_req),
      .alloc_num           (alloc_num),
      .rat_update_en       (rat_update_en),
      .pipe_load           (pipe_load),
      .rename_valid        (rename_valid),
      .rat_recover_en      (rat_recover_en),
      .freelist_recover_en (freelist_recover_en),
      .recovering          (recovering)
   );

   typedef struct packed {
      logic       dec;
      logic [3:0] iv;
      logic [3:0] rd;
      logic [7:0] fl;
      logic       dr;
      logic       fls;
      logic       rdy;
      logic       req;
      logic [2:0] num;
      logic       rv_next;
   } vec_t;

   vec_t vecs [0:10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic dec, input logic [3:0] iv, input logic [3:0] rd,
                         input logic [7:0] fl, input logic dr, input logic fls, input logic rec);
      decoder_valid   = dec;
      instr_valid_vec = iv;
      rd_exist_vec    = rd;
      freelist_count  = fl;
      dispatch_ready  = dr;
      rename_flush    = fls;
      recover_valid   = rec;
   endtask

   // Advance one clock and land mid-low-phase of the next cycle.
   task automatic next_cyc();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      //          dec   iv     rd      fl     dr    fls   rdy   req   num   rv_next
      vecs[0]  = '{1'b1, 4'hF, 4'b1011, 8'd10, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1};
      vecs[1]  = '{1'b1, 4'hF, 4'b1111, 8'd2,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
      vecs[2]  = '{1'b1, 4'hF, 4'b1011, 8'd2,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
      vecs[3]  = '{1'b1, 4'hF, 4'b1011, 8'd3,  1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1};
      vecs[4]  = '{1'b1, 4'hF, 4'b0000, 8'd0,  1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};
      vecs[5]  = '{1'b1, 4'b0101, 4'hF, 8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
      vecs[6]  = '{1'b0, 4'hF, 4'hF,    8'd8,  1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
      vecs[7]  = '{1'b1, 4'b0110, 4'b0011, 8'd8, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1};
      vecs[8]  = '{1'b1, 4'b0110, 4'b0011, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
      vecs[9]  = '{1'b1, 4'hF, 4'b1011, 8'd10, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
      vecs[10] = '{1'b1, 4'b1000, 4'b1000, 8'd1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1};

      // Reset: all outputs low even with a fireable group presented.
      rst_n = 1'b0;
      set_in(1'b1, 4'hF, 4'b1011, 8'd10, 1'b1, 1'b0, 1'b0);
      #3;
      chk("rst_ready", 32'(rename_ready), 32'd0);
      chk("rst_pipe_load", 32'(pipe_load), 32'd0);
      chk("rst_alloc_req", 32'(alloc_req), 32'd0);
      chk("rst_rename_valid", 32'(rename_valid), 32'd0);
      chk("rst_recovering", 32'(recovering), 32'd0);
      chk("rst_rat_recover", 32'(rat_recover_en), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         set_in(vecs[i].dec, vecs[i].iv, vecs[i].rd, vecs[i].fl, vecs[i].dr, vecs[i].fls, 1'b0);
         #1;
         chk($sformatf("v%0d_ready", i), 32'(rename_ready), 32'(vecs[i].rdy));
         chk($sformatf("v%0d_alloc_req", i), 32'(alloc_req), 32'(vecs[i].req));
         chk($sformatf("v%0d_alloc_num", i), 32'(alloc_num), 32'(vecs[i].num));
         chk($sformatf("v%0d_pipe_load", i), 32'(pipe_load), 32'(vecs[i].dec & vecs[i].rdy));
         chk($sformatf("v%0d_rat_update", i), 32'(rat_update_en), 32'(vecs[i].dec & vecs[i].rdy));
         chk($sformatf("v%0d_recovering", i), 32'(recovering), 32'd0);
         next_cyc();
         chk($sformatf("v%0d_rename_valid", i), 32'(rename_valid), 32'(vecs[i].rv_next));
      end

      // Backpressure: rename_valid held with dispatch stalled for 3 cycles.
      for (int c = 0; c < 3; c++) begin
         set_in(1'b1, 4'hF, 4'b1011, 8'd10, 1'b0, 1'b0, 1'b0);
         #1;
         chk($sformatf("bp%0d_ready", c), 32'(rename_ready), 32'd0);
         chk($sformatf("bp%0d_pipe_load", c), 32'(pipe_load), 32'd0);
         next_cyc();
         chk($sformatf("bp%0d_rename_valid", c), 32'(rename_valid), 32'd1);
      end
      set_in(1'b1, 4'hF, 4'b1011, 8'd10, 1'b1, 1'b0, 1'b0);
      #1;
      chk("bp_release_pipe_load", 32'(pipe_load), 32'd1);
      chk("bp_release_alloc_num", 32'(alloc_num), 32'd3);
      next_cyc();

      // Recovery pulse at T with a fireable group; rename_valid is 1 entering T.
      recover_valid = 1'b1;
      #1;
      chk("rec_T_pipe_load", 32'(pipe_load), 32'd0);
      chk("rec_T_alloc_req", 32'(alloc_req), 32'd0);
      chk("rec_T_rat_recover", 32'(rat_recover_en), 32'd0);
      next_cyc();
      recover_valid = 1'b0;
      #1;
      chk("rec_T1_recovering", 32'(recovering), 32'd1);
      chk("rec_T1_rat_recover", 32'(rat_recover_en), 32'd1);
      chk("rec_T1_fl_recover", 32'(freelist_recover_en), 32'd1);
      chk("rec_T1_rename_valid", 32'(rename_valid), 32'd0);
      chk("rec_T1_pipe_load", 32'(pipe_load), 32'd0);
      for (int c = 2; c <= 3; c++) begin
         next_cyc();
         chk($sformatf("rec_T%0d_recovering", c), 32'(recovering), 32'd1);
         chk($sformatf("rec_T%0d_rat_recover", c), 32'(rat_recover_en), 32'd0);
         chk($sformatf("rec_T%0d_pipe_load", c), 32'(pipe_load), 32'd0);
         chk($sformatf("rec_T%0d_rename_valid", c), 32'(rename_valid), 32'd0);
      end
      next_cyc();
      chk("rec_T4_recovering", 32'(recovering), 32'd0);
      chk("rec_T4_pipe_load", 32'(pipe_load), 32'd1);
      next_cyc();
      chk("rec_T5_rename_valid", 32'(rename_valid), 32'd1);

      // Second recovery pulse during SETTLE restarts the sequence.
      set_in(1'b0, 4'hF, 4'b1011, 8'd10, 1'b1, 1'b0, 1'b1);
      next_cyc();
      recover_valid = 1'b0;
      #1;
      chk("rr_T1_rat_recover", 32'(rat_recover_en), 32'd1);
      next_cyc();
      recover_valid = 1'b1;
      #1;
      chk("rr_T2_settle", 32'(recovering), 32'd1);
      chk("rr_T2_rat_recover", 32'(rat_recover_en), 32'd0);
      next_cyc();
      recover_valid = 1'b0;
      #1;
      chk("rr_T3_rat_recover", 32'(rat_recover_en), 32'd1);
      for (int c = 4; c <= 5; c++) begin
         next_cyc();
         chk($sformatf("rr_T%0d_recovering", c), 32'(recovering), 32'd1);
         chk($sformatf("rr_T%0d_rat_recover", c), 32'(rat_recover_en), 32'd0);
      end
      next_cyc();
      decoder_valid = 1'b1;
      #1;
      chk("rr_T6_recovering", 32'(recovering), 32'd0);
      chk("rr_T6_pipe_load", 32'(pipe_load), 32'd1);
      next_cyc();

      // Reset during RECOVER returns to RUN with no restore pulse.
      recover_valid = 1'b1;
      next_cyc();
      recover_valid = 1'b0;
      #1;
      chk("rm_in_recover", 32'(rat_recover_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rm_rst_rat_recover", 32'(rat_recover_en), 32'd0);
      chk("rm_rst_recovering", 32'(recovering), 32'd0);
      chk("rm_rst_ready", 32'(rename_ready), 32'd0);
      next_cyc();
      rst_n = 1'b1;
      #1;
      chk("rm_run_recovering", 32'(recovering), 32'd0);
      chk("rm_run_fl_recover", 32'(freelist_recover_en), 32'd0);
      chk("rm_run_pipe_load", 32'(pipe_load), 32'd1);
      next_cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
